// File: rtl/quad_gather_pkg.sv
// Shared defaults and helpers for the 2x2 quad gatherer feeding the radix-2x2 butterfly.
package quad_gather_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int N_DEF      = 8;

    // Index width for an N-entry row; N is a power of two >= 2.
    function automatic int col_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // What an accepted sample does, given its (row, col) parity.
    typedef enum logic [1:0] {
        SLOT_WRITE_TOP = 2'd0,
        SLOT_HOLD_BL   = 2'd1,
        SLOT_EMIT_QUAD = 2'd2
    } slot_e;

endpackage

// File: rtl/quad_line_buf.sv
// One-row complex line buffer: single write port, two combinational read ports.
module quad_line_buf
    import quad_gather_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int COL_W  = col_w(N)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [COL_W-1:0]      waddr,
    input  logic [2*DATA_W-1:0]   wdata,
    input  logic [COL_W-1:0]      raddr_a,
    input  logic [COL_W-1:0]      raddr_b,
    output logic [2*DATA_W-1:0]   rdata_a,
    output logic [2*DATA_W-1:0]   rdata_b
);

    logic [2*DATA_W-1:0] mem_q [N];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/quad_gather.sv
// Row-major sample stream in, registered 2x2 quads out: one quad per odd-row/odd-col sample.
module quad_gather
    import quad_gather_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_i,
    output logic              out_valid,
    output logic              out_sof,
    output logic [DATA_W-1:0] out_1_1_r,
    output logic [DATA_W-1:0] out_1_1_i,
    output logic [DATA_W-1:0] out_1_2_r,
    output logic [DATA_W-1:0] out_1_2_i,
    output logic [DATA_W-1:0] out_2_1_r,
    output logic [DATA_W-1:0] out_2_1_i,
    output logic [DATA_W-1:0] out_2_2_r,
    output logic [DATA_W-1:0] out_2_2_i,
    output logic              frame_err
);

    localparam int COL_W = col_w(N);
    localparam logic [COL_W-1:0] LAST = COL_W'(N - 1);

    logic [COL_W-1:0]    col_q, col_d, row_q, row_d;
    logic [COL_W-1:0]    eff_col, eff_row;
    logic                sof_pend_q, sof_pend_d;
    logic [DATA_W-1:0]   bl_r_q, bl_i_q;
    logic                restart, emit, hold_bl, lb_we;
    slot_e               slot;
    logic [2*DATA_W-1:0] lb_rd_a, lb_rd_b;

    logic                out_valid_q, out_sof_q, frame_err_q;
    logic [DATA_W-1:0]   q11_r_q, q11_i_q, q12_r_q, q12_i_q;
    logic [DATA_W-1:0]   q21_r_q, q21_i_q, q22_r_q, q22_i_q;

    quad_line_buf #(
        .N      (N),
        .DATA_W (DATA_W),
        .COL_W  (COL_W)
    ) u_line_buf (
        .clk     (clk),
        .we      (lb_we),
        .waddr   (eff_col),
        .wdata   ({in_r, in_i}),
        .raddr_a (eff_col - COL_W'(1)),
        .raddr_b (eff_col),
        .rdata_a (lb_rd_a),
        .rdata_b (lb_rd_b)
    );

    always_comb begin
        // A misplaced in_sof re-labels the current sample as (0,0) of a fresh tile.
        restart    = in_valid && in_sof && ((row_q != '0) || (col_q != '0));
        eff_row    = restart ? '0 : row_q;
        eff_col    = restart ? '0 : col_q;
        col_d      = col_q;
        row_d      = row_q;
        sof_pend_d = sof_pend_q;

        if (!eff_row[0]) begin
            slot = SLOT_WRITE_TOP;
        end else if (!eff_col[0]) begin
            slot = SLOT_HOLD_BL;
        end else begin
            slot = SLOT_EMIT_QUAD;
        end

        lb_we   = in_valid && (slot == SLOT_WRITE_TOP);
        hold_bl = in_valid && (slot == SLOT_HOLD_BL);
        emit    = in_valid && (slot == SLOT_EMIT_QUAD);

        if (in_valid) begin
            if (eff_col == LAST) begin
                col_d = '0;
                row_d = (eff_row == LAST) ? '0 : eff_row + COL_W'(1);
            end else begin
                col_d = eff_col + COL_W'(1);
                row_d = eff_row;
            end
            if (in_sof) begin
                sof_pend_d = 1'b1;
            end else if (emit) begin
                sof_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            sof_pend_q  <= 1'b0;
            bl_r_q      <= '0;
            bl_i_q      <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            frame_err_q <= 1'b0;
            q11_r_q     <= '0;
            q11_i_q     <= '0;
            q12_r_q     <= '0;
            q12_i_q     <= '0;
            q21_r_q     <= '0;
            q21_i_q     <= '0;
            q22_r_q     <= '0;
            q22_i_q     <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            sof_pend_q  <= sof_pend_d;
            out_valid_q <= emit;
            out_sof_q   <= emit && sof_pend_q;
            frame_err_q <= restart;
            if (hold_bl) begin
                bl_r_q <= in_r;
                bl_i_q <= in_i;
            end
            // Quad data holds between pulses; only an emitting sample reloads it.
            if (emit) begin
                q11_r_q <= lb_rd_a[2*DATA_W-1:DATA_W];
                q11_i_q <= lb_rd_a[DATA_W-1:0];
                q12_r_q <= lb_rd_b[2*DATA_W-1:DATA_W];
                q12_i_q <= lb_rd_b[DATA_W-1:0];
                q21_r_q <= bl_r_q;
                q21_i_q <= bl_i_q;
                q22_r_q <= in_r;
                q22_i_q <= in_i;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign frame_err = frame_err_q;
    assign out_1_1_r = q11_r_q;
    assign out_1_1_i = q11_i_q;
    assign out_1_2_r = q12_r_q;
    assign out_1_2_i = q12_i_q;
    assign out_2_1_r = q21_r_q;
    assign out_2_1_i = q21_i_q;
    assign out_2_2_r = q22_r_q;
    assign out_2_2_i = q22_i_q;

endmodule

// File: doc/quad_gather.md
Name: quad_gather

Overview:
- Upstream feeder for the 2x2 radix butterfly in the 4-parallel 2D FFT.
- Accepts one complex sample per valid cycle, streamed row-major over an N x N tile.
- Buffers one even row and emits each 2x2 neighbourhood as a registered quad (1_1, 1_2, 2_1, 2_2) with a valid strobe, aligned to the butterfly input ports.
- No backpressure: the butterfly accepts a quad every cycle.

Parameters:
- N, 8: row length and row count of a tile; power of two, >= 2.
- DATA_W, 16: width of each real/imag component; equals the butterfly input bus width in std_define.h.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_r/in_i/in_sof valid this cycle.
- in_sof  in  1  first sample of a tile; qualified by in_valid.
- in_r  in  DATA_W  sample real, signed.
- in_i  in  DATA_W  sample imag, signed.
- out_valid  out  1  quad valid, single-cycle pulse per quad.
- out_sof  out  1  high with first quad of a tile.
- out_1_1_r, out_1_1_i  out  DATA_W each  top-left, (even row, even col).
- out_1_2_r, out_1_2_i  out  DATA_W each  top-right, (even row, odd col).
- out_2_1_r, out_2_1_i  out  DATA_W each  bottom-left, (odd row, even col).
- out_2_2_r, out_2_2_i  out  DATA_W each  bottom-right, (odd row, odd col).
- frame_err  out  1  one-cycle pulse on an in_sof not at tile start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - col=0, row=0, sof_pend=0.
  - All outputs 0; line buffer contents don't-care.
- Counters advance only on in_valid. col wraps N-1 -> 0 and increments row; row wraps N-1 -> 0.
- Idle cycles (in_valid=0) may occur anywhere; state is held and the outputs hold their last values.
- Even row: sample written to line_buf[col]. No output.
- Odd row, even col: sample held in a bottom-left register.
- Odd row, odd col: next edge registers the quad:
  - 1_1 = line_buf[col-1], 1_2 = line_buf[col]
  - 2_1 = held register, 2_2 = current sample
  - out_valid=1 for one cycle.
- Latency: quad appears 1 cycle after the in_valid cycle carrying its bottom-right sample.
- Throughput: N*N/4 quads per tile, N/2 per odd row.
- Width rule: pure data movement; no arithmetic, no sign change, no truncation.
- out_sof:
  - Set sof_pend when in_sof is accepted.
  - out_sof = sof_pend on the first out_valid after that; sof_pend clears at the same time.
- in_sof with in_valid when (row,col) = (0,0): normal tile start.
- in_sof with in_valid elsewhere:
  - frame_err pulses the next cycle.
  - Counters are forced so this sample is (0,0): written to line_buf[0], next sample is col 1.
  - The partial tile is abandoned; no quad is emitted from its data.
- in_valid at (0,0) without in_sof: accepted as tile start; out_sof is not asserted for that tile.
- Reset mid-tile: all progress is discarded and out_valid is low. The first quad after reset requires two fresh rows.
- Tile boundary: the last quad of tile k and the first sample of tile k+1 may be on consecutive cycles without a gap.

Decomposition:
- Shared package/header (std_define.h): DATA_W default, N default, log2(N) derived constant (COL_W), complex sample bundle macro.
- One natural sub-module: quad_line_buf.
  - N-entry complex register array.
  - One write port; two combinational read ports at indices col-1 and col.
  - Keeps the counter/FSM logic in quad_gather separate.

Test Plan (N=4, sample at (row,col): r = 10*row+col, i = -r):
- Tile with in_sof at first sample, no gaps -> 4 quads, each 1 cycle after samples 11, 13, 31, 33:
  - (1_1,1_2,2_1,2_2)_r = (0,1,10,11), (2,3,12,13), (20,21,30,31), (22,23,32,33); imag = negated.
  - out_sof only on the first quad; frame_err stays 0.
- Same tile with in_valid low on every other cycle -> identical quad values. Each out_valid is 1 cycle after its bottom-right sample; outputs hold between pulses.
- Back-to-back tiles, second in_sof immediately after sample 33 -> 8 quads total, out_sof on quads 1 and 5.
- in_sof asserted at sample (2,1) of tile 1:
  - frame_err pulses once; tile 1 emits only its first 2 quads.
  - The restarted tile then emits 4 correct quads, the first with out_sof.
- rst_n low asynchronously after sample (1,0), released, new tile sent -> outputs 0 during reset, no stale quad, then the 4 correct quads.
- Extreme values (DATA_W=16): samples 0x7FFF, 0x8000, 0xFFFF, 0x0001 in one quad -> passed through bit-exact.
